// File: rtl/aes_pkg.sv
// Shared AES types and constants: block/word types, the round-key array,
// the forward S-box, the key-schedule round constants and the key FSM states.
package aes_pkg;

    typedef logic [127:0] block128_t;
    typedef logic [31:0]  word32_t;
    typedef block128_t [0:10] rk_array_t;

    localparam int NR = 10;

    // Forward S-box; element 0 is the leftmost byte of the concatenation
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants for rounds 1..10 (first byte of the round-constant word)
    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } key_state_t;

    // Round constant for a given round; rounds outside 1..10 yield zero
    function automatic logic [7:0] rcon_for(input logic [3:0] round);
        logic [7:0] val;
        val = 8'h00;
        if (round >= 4'd1 && round <= 4'd10) begin
            val = RCON[round];
        end
        return val;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte forward AES S-box lookup (purely combinational).
// Shared by the key schedule (SubWord) and the round core (SubBytes).
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = SBOX[a];

endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: captures a cipher key on key_load and
// produces round keys 1..10 at one per clock into an 11-entry register array.
// key_ready gates the round core; round keys are read through rk_idx/rk.
// Optional build macro AES_KEY_ZEROIZE_EN adds a key_zeroize input that
// clears all round keys and returns the schedule to IDLE.
module aes128_key_expand
    import aes_pkg::*;
#(
    parameter int RK_READ_REG = 0,
    parameter int NR          = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_load,
    input  logic [127:0] key,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic         key_zeroize,
`endif
    output logic         key_ready,
    output logic         key_busy,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk
);

    // Only the AES-128 round count is supported
    generate
        if (NR != aes_pkg::NR) begin : g_nr_check
            $error("aes128_key_expand: NR must be 10 for AES-128");
        end
    endgenerate

    key_state_t state_reg;
    logic [3:0] ctr_reg;
    rk_array_t  rk_mem_reg;
    logic       key_ready_reg;
    logic       key_busy_reg;

    logic [3:0] prev_idx;
    block128_t  prev_rk;
    word32_t    w0, w1, w2, w3;
    word32_t    rot_word;
    word32_t    sub_word;
    word32_t    t_word;
    word32_t    n0, n1, n2, n3;
    block128_t  rk_next;
    block128_t  rk_sel;

    // Previous round key feeds the next round; ctr is always >= 1 in EXPAND
    assign prev_idx = (ctr_reg == 4'd0) ? 4'd0 : ctr_reg - 4'd1;
    assign prev_rk  = rk_mem_reg[prev_idx];
    assign {w0, w1, w2, w3} = prev_rk;

    // RotWord: cyclic left rotate by one byte
    assign rot_word = {w3[23:0], w3[31:24]};

    // SubWord: four S-box lookups, one per byte
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .a (rot_word[8*gi +: 8]),
                .y (sub_word[8*gi +: 8])
            );
        end
    endgenerate

    assign t_word  = sub_word ^ {rcon_for(ctr_reg), 24'h000000};
    assign n0      = w0 ^ t_word;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    // Key FSM: load/restart, one round key per cycle, zeroize and reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            ctr_reg       <= 4'd0;
            rk_mem_reg    <= '0;
            key_ready_reg <= 1'b0;
            key_busy_reg  <= 1'b0;
        end
`ifdef AES_KEY_ZEROIZE_EN
        else if (key_zeroize) begin
            state_reg     <= IDLE;
            ctr_reg       <= 4'd0;
            rk_mem_reg    <= '0;
            key_ready_reg <= 1'b0;
            key_busy_reg  <= 1'b0;
        end
`endif
        else if (key_load) begin
            // A new key always restarts the schedule, abandoning any partial one
            state_reg     <= EXPAND;
            rk_mem_reg[0] <= key;
            ctr_reg       <= 4'd1;
            key_ready_reg <= 1'b0;
            key_busy_reg  <= 1'b1;
        end else begin
            case (state_reg)
                EXPAND: begin
                    rk_mem_reg[ctr_reg] <= rk_next;
                    if (ctr_reg == 4'(NR)) begin
                        // Counter parks at 10 rather than wrapping
                        state_reg     <= READY;
                        key_ready_reg <= 1'b1;
                        key_busy_reg  <= 1'b0;
                    end else begin
                        ctr_reg <= ctr_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= state_reg;
                end
            endcase
        end
    end

    assign key_ready = key_ready_reg;
    assign key_busy  = key_busy_reg;

    // Round-key select; indices past the last round read as zero
    always_comb begin
        rk_sel = '0;
        if (rk_idx <= 4'(NR)) begin
            rk_sel = rk_mem_reg[rk_idx];
        end
    end

    generate
        if (RK_READ_REG != 0) begin : g_rd_reg
            block128_t rk_q_reg;
            // Registered read port: one cycle of latency from rk_idx to rk
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rk_q_reg <= '0;
                end else begin
                    rk_q_reg <= rk_sel;
                end
            end
            assign rk = rk_q_reg;
        end else begin : g_rd_comb
            assign rk = rk_sel;
        end
    endgenerate

endmodule

// File: tb/tb_aes128_key_expand.sv
// Directed testbench for aes128_key_expand using FIPS-197 key-schedule vectors.
// Two instances share stimulus: combinational read port and registered read port.
module tb_aes128_key_expand;

    localparam logic [127:0] KA     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KA_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KA_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] KA_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] KA_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KB     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KB_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KB_R2  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    localparam logic [127:0] KB_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_load;
    logic [127:0] key;
    logic         key_zeroize;
    logic [3:0]   rk_idx;
    logic         key_ready, key_busy;
    logic         key_ready_r, key_busy_r;
    logic [127:0] rk, rk_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes128_key_expand #(.RK_READ_REG(0), .NR(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_load    (key_load),
        .key         (key),
`ifdef AES_KEY_ZEROIZE_EN
        .key_zeroize (key_zeroize),
`endif
        .key_ready   (key_ready),
        .key_busy    (key_busy),
        .rk_idx      (rk_idx),
        .rk          (rk)
    );

    aes128_key_expand #(.RK_READ_REG(1), .NR(10)) dut_reg (
        .clk         (clk),
        .reset       (reset),
        .key_load    (key_load),
        .key         (key),
`ifdef AES_KEY_ZEROIZE_EN
        .key_zeroize (key_zeroize),
`endif
        .key_ready   (key_ready_r),
        .key_busy    (key_busy_r),
        .rk_idx      (rk_idx),
        .rk          (rk_r)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse key_load, then confirm ready rises exactly 10 edges after the load edge
    task automatic do_load(input logic [127:0] k);
        $display("load key=%h", k);
        key      = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        chk1("load_busy", key_busy, 1'b1);
        chk1("load_ready", key_ready, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step();
            chk1("expand_not_ready", key_ready, 1'b0);
        end
        step();
        chk1("done_ready", key_ready, 1'b1);
        chk1("done_busy", key_busy, 1'b0);
        chk1("done_ready_reg_inst", key_ready_r, 1'b1);
    endtask

    task automatic read_chk(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        rk_idx = idx;
        #1;
        $display("read idx=%0d rk=%h", idx, rk);
        chk128(tag, rk, exp);
    endtask

    initial begin
        reset       = 1'b1;
        key_load    = 1'b0;
        key         = '0;
        key_zeroize = 1'b0;
        rk_idx      = 4'd0;
        step();
        step();
        chk1("rst_ready", key_ready, 1'b0);
        chk1("rst_busy", key_busy, 1'b0);
        chk128("rst_rk", rk, '0);
        chk128("rst_rk_reg", rk_r, '0);
        reset = 1'b0;
        step();

        // FIPS-197 A.1 key
        do_load(KA);
        read_chk("ka_r0", 4'd0, KA);
        read_chk("ka_r1", 4'd1, KA_R1);
        read_chk("ka_r2", 4'd2, KA_R2);
        read_chk("ka_r9", 4'd9, KA_R9);
        step();
        chk128("reg_r9", rk_r, KA_R9);
        rk_idx = 4'd10;
        #1;
        chk128("ka_r10", rk, KA_R10);
        chk128("reg_latency_old", rk_r, KA_R9);
        step();
        chk128("reg_latency_new", rk_r, KA_R10);

        // Out-of-range indices
        for (int i = 11; i <= 15; i++) begin
            rk_idx = 4'(i);
            step();
            chk128("oob_rk", rk, '0);
            chk128("oob_rk_reg", rk_r, '0);
        end

        // Key change without key_load has no effect
        key = KB;
        step(); step(); step();
        chk1("nochange_ready", key_ready, 1'b1);
        read_chk("nochange_r1", 4'd1, KA_R1);

        // FIPS-197 C.1 key
        do_load(KB);
        read_chk("kb_r0", 4'd0, KB);
        read_chk("kb_r1", 4'd1, KB_R1);
        read_chk("kb_r10", 4'd10, KB_R10);

        // Restart mid-expansion: second load four edges after the first
        key      = KA;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        step(); step(); step();
        chk1("restart_busy", key_busy, 1'b1);
        do_load(KB);
        read_chk("restart_r1", 4'd1, KB_R1);
        read_chk("restart_r2", 4'd2, KB_R2);
        read_chk("restart_r10", 4'd10, KB_R10);

        // key_load in the cycle round 10 is written wins
        key      = KA;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        for (int i = 1; i <= 9; i++) step();
        do_load(KB);
        read_chk("late_load_r10", 4'd10, KB_R10);
        read_chk("late_load_r1", 4'd1, KB_R1);

        // Asynchronous reset in the middle of expansion
        key      = KA;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        for (int i = 1; i <= 6; i++) step();
        #2;
        reset = 1'b1;
        #1;
        chk1("arst_ready", key_ready, 1'b0);
        chk1("arst_busy", key_busy, 1'b0);
        chk128("arst_rk_reg", rk_r, '0);
        for (int i = 0; i <= 10; i++) begin
            read_chk("arst_rk", 4'(i), '0);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk1("post_rst_ready", key_ready, 1'b0);
        chk1("post_rst_busy", key_busy, 1'b0);
        read_chk("post_rst_r1", 4'd1, '0);

`ifdef AES_KEY_ZEROIZE_EN
        do_load(KA);
        key_zeroize = 1'b1;
        step();
        key_zeroize = 1'b0;
        chk1("zero_ready", key_ready, 1'b0);
        chk1("zero_busy", key_busy, 1'b0);
        for (int i = 0; i <= 10; i++) begin
            read_chk("zero_rk", 4'(i), '0);
        end
        key         = KB;
        key_load    = 1'b1;
        key_zeroize = 1'b1;
        step();
        key_load    = 1'b0;
        key_zeroize = 1'b0;
        chk1("zero_vs_load_busy", key_busy, 1'b0);
        for (int i = 0; i < 12; i++) step();
        chk1("zero_vs_load_idle", key_ready, 1'b0);
        read_chk("zero_vs_load_r0", 4'd0, '0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes128_key_expand.md
Name: aes128_key_expand

Overview:
- Iterative AES-128 key schedule (FIPS-197 §5.2) that sits directly upstream of the round core inside aes128_top.
- Captures a 128-bit cipher key and generates round keys 1..10 at one round key per clock.
- Stores all 11 round keys in a register array and raises key_ready, which the core uses to gate its start.
- The core reads round keys through an indexed read port.

Parameters:
- RK_READ_REG, 0: 0 = combinational round-key read; 1 = registered read with 1-cycle latency.
- NR, 10: number of rounds. Fixed at 10 for AES-128; any other value is a compile-time error.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- key_load  in  1  single-cycle pulse; samples key and starts expansion
- key  in  128  cipher key, FIPS byte order (MSB = byte 0)
- key_ready  out  1  high when all 11 round keys are valid
- key_busy  out  1  high while expansion is in progress
- rk_idx  in  4  round-key index, 0..10
- rk  out  128  round key selected by rk_idx

Behaviour:
- Reset (async assert, sync deassert in the system): state=IDLE; key_ready=0; key_busy=0; round counter=0; all round-key registers=0; rk=0 (also the registered copy when RK_READ_REG=1).
- FSM states and transitions:
  - IDLE -> EXPAND on key_load.
  - EXPAND -> READY after round 10 is written.
  - READY -> EXPAND on key_load.
- key_load accepted in any state, including mid-EXPAND. On that edge:
  - rk_mem[0] <= key; ctr <= 1; key_ready <= 0; key_busy <= 1.
  - A partially expanded schedule is abandoned.
- EXPAND, each cycle, with prev = rk_mem[ctr-1] split into words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {RCON[ctr],24'h0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2
  - rk_mem[ctr] <= {n0,n1,n2,n3}; ctr <= ctr+1
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Latency: key_load sampled at edge E. rk_mem[i] is written at edge E+i. key_ready=1 and key_busy=0 after edge E+10. The final expansion cycle transitions to READY.
- key_ready stays high in READY until the next key_load or reset. A key change without key_load has no effect.
- Read port:
  - rk = rk_mem[rk_idx] (RK_READ_REG=0), or the same value registered (RK_READ_REG=1).
  - rk_idx 11..15 returns 128'h0.
  - Reads during EXPAND return the current register contents. The core must not read before key_ready.
- key_load coincident with reset: reset wins.
- key_load in the same cycle that round 10 is written: key_load wins; key_ready stays 0.
- Round counter is 4-bit and never exceeds 10. No wrap occurs.

Optional Feature:
- Macro AES_KEY_ZEROIZE_EN.
- Defined:
  - Adds input port key_zeroize (1 bit).
  - When high at a clock edge: all 11 round keys <= 0, key_ready <= 0, key_busy <= 0, state <= IDLE.
  - Priority: reset > key_zeroize > key_load.
- Not defined: port absent; round keys are retained until the next key_load or reset.

Decomposition:
- Package aes_pkg holds:
  - typedef block128_t (logic [127:0])
  - typedef word32_t
  - typedef rk_array_t (block128_t [0:10])
  - localparam NR=10
  - constant SBOX[256]
  - constant RCON[1:10]
  - FSM enum key_state_t {IDLE, EXPAND, READY}
- Sub-module aes_sbox: one combinational byte S-box lookup, instantiated 4 times for SubWord. The round core reuses the same module.

Test Plan:
- Reset, then key_load with key=2b7e151628aed2a6abf7158809cf4f3c -> key_ready rises exactly 10 cycles after the load edge. rk_idx=1 gives a0fafe1788542cb123a339392a6c7605. rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- key_load with key=000102030405060708090a0b0c0d0e0f -> rk_idx=0 returns the key. rk_idx=1 gives d6aa74fdd2af72fadaa678f1d6ab76fe. rk_idx=10 gives 13111d7fe3944a17f307a78b4d2b30c5. Feeding the core with plaintext 00112233445566778899aabbccddeeff yields 69c4e0d86a7b0430d8cdb78070b4c55a.
- Restart mid-expansion: first key loaded, second key_load at cycle 4 -> key_ready stays 0 and rises 10 cycles after the second load. Schedule matches the second key only.
- Reset asserted mid-EXPAND (cycle 6) -> immediately key_ready=0, key_busy=0, rk=0 for all idx. No expansion resumes after deassert until a new key_load.
- rk_idx=11..15 in READY -> rk=0. With RK_READ_REG=1, rk updates one cycle after rk_idx changes.
- With AES_KEY_ZEROIZE_EN defined: key_zeroize pulse in READY -> key_ready=0 next cycle and all rk_idx return 0. key_zeroize and key_load in the same cycle -> zeroize wins and the state is IDLE.
